pid_ctrl_tdm: RTL and testbench

Time-division-multiplexed, multi-channel PID controller. Successor to the single-channel fixed-gain PID: it adds runtime-programmable gains, setpoint and integrator limit per channel, plus a valid/ready input, rounding and saturating output, and per-channel state clear. It sits between the phase/measurement front-ends and the loop actuators (NCO/DAC trims), and serves up to N_CH loops from one multiplier set.

---
 rtl/pid_ctrl_tdm_pkg.sv | 18 +
 rtl/pid_ctrl_tdm_if.sv | 29 ++
 rtl/pid_round_sat.sv | 19 +
 rtl/pid_ctrl_tdm.sv | 139 +++++++++++++
 tb/tb_pid_ctrl_tdm.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pid_ctrl_tdm_pkg.sv
// pid_ctrl_tdm_pkg: shared constants, config address map and width helpers for the TDM PID
package pid_ctrl_tdm_pkg;
  typedef enum logic [2:0] {
    CFG_KP       = 3'd0,
    CFG_KI       = 3'd1,
    CFG_KD       = 3'd2,
    CFG_INT_LIM  = 3'd3,
    CFG_SETPOINT = 3'd4
  } cfg_addr_e;
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  function automatic int prod_w(input int a, input int b);
    return a + b;
  endfunction
  function automatic int sum_w(input int a, input int b, input int c);
    return (a > b ? (a > c ? a : c) : (b > c ? b : c)) + 2;
  endfunction
endpackage

// File: rtl/pid_ctrl_tdm_if.sv
// pid_ctrl_tdm_if: sample, config and result signals of the TDM PID
interface pid_ctrl_tdm_if #(
  parameter int CH_W      = 2,
  parameter int ERR_WIDTH = 12,
  parameter int INT_WIDTH = 20,
  parameter int OUT_WIDTH = 16
);
  logic                        s_valid;
  logic                        s_ready;
  logic [CH_W-1:0]             s_ch;
  logic signed [ERR_WIDTH-1:0] s_meas;
  logic                        cfg_we;
  logic [CH_W-1:0]             cfg_ch;
  logic [2:0]                  cfg_addr;
  logic [INT_WIDTH-1:0]        cfg_wdata;
  logic                        cfg_clr;
  logic                        m_valid;
  logic [CH_W-1:0]             m_ch;
  logic signed [OUT_WIDTH-1:0] m_pid;
  logic                        m_sat;
  modport master (
    output s_valid, s_ch, s_meas, cfg_we, cfg_ch, cfg_addr, cfg_wdata, cfg_clr,
    input  s_ready, m_valid, m_ch, m_pid, m_sat
  );
  modport slave (
    input  s_valid, s_ch, s_meas, cfg_we, cfg_ch, cfg_addr, cfg_wdata, cfg_clr,
    output s_ready, m_valid, m_ch, m_pid, m_sat
  );
endinterface

// File: rtl/pid_round_sat.sv
// pid_round_sat: round-half-up right shift by FRAC, then saturate to OUT_W with a clip flag
module pid_round_sat #(
  parameter int IN_W  = 34,
  parameter int FRAC  = 10,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);
  localparam int W1 = IN_W + 1;
  localparam logic signed [IN_W:0] HALF = (W1'(1) << FRAC) >> 1;
  localparam logic signed [IN_W:0] MAXV = W1'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W:0] MINV = ~MAXV;
  logic signed [IN_W:0] sh;
  assign sh   = ($signed({din[IN_W-1], din}) + HALF) >>> FRAC;
  assign sat  = sh > MAXV || sh < MINV;
  assign dout = sh > MAXV ? MAXV[OUT_W-1:0] : sh < MINV ? MINV[OUT_W-1:0] : sh[OUT_W-1:0];
endmodule

// File: rtl/pid_ctrl_tdm.sv
// pid_ctrl_tdm: time-multiplexed multi-channel PID with programmable gains and saturating output
module pid_ctrl_tdm
  import pid_ctrl_tdm_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int ERR_WIDTH  = 12,
  parameter int COEF_WIDTH = 12,
  parameter int COEF_FRAC  = 10,
  parameter int INT_WIDTH  = 20,
  parameter int OUT_WIDTH  = 16
) (
  input logic           clk,
  input logic           rst_n,
  pid_ctrl_tdm_if.slave io
);
  localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int DW   = ERR_WIDTH + 1;
  localparam int IW1  = INT_WIDTH + 1;
  localparam int PW_P = prod_w(COEF_WIDTH, ERR_WIDTH);
  localparam int PW_I = prod_w(COEF_WIDTH, INT_WIDTH);
  localparam int PW_D = prod_w(COEF_WIDTH, DW);
  localparam int SW   = sum_w(PW_P, PW_I, PW_D);
  localparam logic [INT_WIDTH-1:0] LIM_CAP = {1'b0, {(INT_WIDTH-1){1'b1}}};
  logic [0:0]                   state;
  logic [CH_W-1:0]              init_ch;
  logic signed [COEF_WIDTH-1:0] kp [N_CH];
  logic signed [COEF_WIDTH-1:0] ki [N_CH];
  logic signed [COEF_WIDTH-1:0] kd [N_CH];
  logic [INT_WIDTH-1:0]         lim [N_CH];
  logic signed [ERR_WIDTH-1:0]  sp [N_CH];
  logic signed [INT_WIDTH-1:0]  integ [N_CH];
  logic signed [ERR_WIDTH-1:0]  prev_err [N_CH];
  logic                         accept;
  logic signed [DW-1:0]         raw_err;
  logic signed [ERR_WIDTH-1:0]  err_sat;
  logic                         unused_err_clip;
  logic                         s1_v, s2_v, s3_v;
  logic [CH_W-1:0]              s1_ch, s2_ch, s3_ch;
  logic signed [ERR_WIDTH-1:0]  s1_err, s2_err;
  logic signed [IW1-1:0]        integ_sum, lim_s, neg_lim;
  logic signed [INT_WIDTH-1:0]  integ_new, s2_integ;
  logic signed [DW-1:0]         diff, s2_diff;
  logic signed [PW_P-1:0]       s3_p;
  logic signed [PW_I-1:0]       s3_i;
  logic signed [PW_D-1:0]       s3_d;
  logic signed [SW-1:0]         sum;
  logic signed [OUT_WIDTH-1:0]  pid_out;
  logic                         pid_clip;
  assign io.s_ready = state == ST_RUN;
  assign accept     = io.s_valid && io.s_ready;
  assign raw_err    = DW'(sp[io.s_ch]) - DW'(io.s_meas);
  pid_round_sat #(.IN_W(DW), .FRAC(0), .OUT_W(ERR_WIDTH)) u_err_sat (
    .din(raw_err), .dout(err_sat), .sat(unused_err_clip)
  );
  assign lim_s     = $signed({1'b0, lim[s1_ch][INT_WIDTH-1] ? LIM_CAP : lim[s1_ch]});
  assign neg_lim   = -lim_s;
  assign integ_sum = IW1'(integ[s1_ch]) + IW1'(s1_err);
  assign integ_new = integ_sum > lim_s ? lim_s[INT_WIDTH-1:0] :
                     integ_sum < neg_lim ? neg_lim[INT_WIDTH-1:0] : integ_sum[INT_WIDTH-1:0];
  assign diff      = DW'(s1_err) - DW'(prev_err[s1_ch]);
  assign sum       = SW'(s3_p) + SW'(s3_i) + SW'(s3_d);
  pid_round_sat #(.IN_W(SW), .FRAC(COEF_FRAC), .OUT_W(OUT_WIDTH)) u_out_sat (
    .din(sum), .dout(pid_out), .sat(pid_clip)
  );
  // INIT sweep zeroes per-channel state; in RUN the S2 update applies, then a clear overrides it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      init_ch <= '0;
    end else if (state == ST_INIT) begin
      integ[init_ch]    <= '0;
      prev_err[init_ch] <= '0;
      init_ch           <= init_ch + CH_W'(1);
      if (init_ch == CH_W'(N_CH - 1)) state <= ST_RUN;
    end else begin
      if (s1_v) begin
        integ[s1_ch]    <= integ_new;
        prev_err[s1_ch] <= s1_err;
      end
      if (io.cfg_clr) begin
        integ[io.cfg_ch]    <= '0;
        prev_err[io.cfg_ch] <= '0;
      end
    end
  end
  // runtime configuration registers, writable in any state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        kp[c]  <= '0;
        ki[c]  <= '0;
        kd[c]  <= '0;
        lim[c] <= '0;
        sp[c]  <= '0;
      end
    end else if (io.cfg_we) begin
      if (io.cfg_addr == CFG_KP) kp[io.cfg_ch] <= io.cfg_wdata[COEF_WIDTH-1:0];
      if (io.cfg_addr == CFG_KI) ki[io.cfg_ch] <= io.cfg_wdata[COEF_WIDTH-1:0];
      if (io.cfg_addr == CFG_KD) kd[io.cfg_ch] <= io.cfg_wdata[COEF_WIDTH-1:0];
      if (io.cfg_addr == CFG_INT_LIM) lim[io.cfg_ch] <= io.cfg_wdata;
      if (io.cfg_addr == CFG_SETPOINT) sp[io.cfg_ch] <= io.cfg_wdata[ERR_WIDTH-1:0];
    end
  end
  // valid chain and result registers; reset drops anything in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v       <= 1'b0;
      s2_v       <= 1'b0;
      s3_v       <= 1'b0;
      io.m_valid <= 1'b0;
      io.m_ch    <= '0;
      io.m_pid   <= '0;
      io.m_sat   <= 1'b0;
    end else begin
      s1_v       <= accept;
      s2_v       <= s1_v;
      s3_v       <= s2_v;
      io.m_valid <= s3_v;
      if (s3_v) begin
        io.m_ch  <= s3_ch;
        io.m_pid <= pid_out;
        io.m_sat <= pid_clip;
      end
    end
  end
  // datapath registers S1..S3, qualified by the valid chain
  always_ff @(posedge clk) begin
    s1_ch    <= io.s_ch;
    s1_err   <= err_sat;
    s2_ch    <= s1_ch;
    s2_err   <= s1_err;
    s2_integ <= integ_new;
    s2_diff  <= diff;
    s3_ch    <= s2_ch;
    s3_p     <= PW_P'(kp[s2_ch]) * PW_P'(s2_err);
    s3_i     <= PW_I'(ki[s2_ch]) * PW_I'(s2_integ);
    s3_d     <= PW_D'(kd[s2_ch]) * PW_D'(s2_diff);
  end
endmodule

// File: tb/tb_pid_ctrl_tdm.sv
// tb_pid_ctrl_tdm: table-driven and scoreboarded checks of the TDM PID
module tb_pid_ctrl_tdm;
  import pid_ctrl_tdm_pkg::*;
  typedef struct {int ch; int pid; bit sat; int cyc;} exp_t;
  typedef struct {int ch; int kp; int sp; int meas; int pid; bit sat;} vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  exp_t sb_q[$];
  vec_t vecs[10];
  pid_ctrl_tdm_if #(.CH_W(2), .ERR_WIDTH(12), .INT_WIDTH(20), .OUT_WIDTH(16)) io ();
  pid_ctrl_tdm #(
    .N_CH(4), .ERR_WIDTH(12), .COEF_WIDTH(12), .COEF_FRAC(10), .INT_WIDTH(20), .OUT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io(io)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask
  // result monitor: pop the oldest expectation on every m_valid
  always @(negedge clk) begin
    if (io.m_valid) begin
      if (sb_q.size() == 0) chk("unexpected_m_valid", longint'(io.m_valid), 0);
      else begin : pop
        exp_t e;
        e = sb_q.pop_front();
        chk("m_ch", longint'(io.m_ch), e.ch);
        chk("m_pid", longint'(io.m_pid), e.pid);
        chk("m_sat", longint'(io.m_sat), e.sat);
        chk("latency", cyc - e.cyc, 4);
      end
    end
  end
  task automatic drive(input bit sv, input int ch, input int meas, input bit we,
                       input int addr, input int data, input bit clr);
    @(negedge clk);
    io.s_valid   = sv;
    io.s_ch      = 2'(ch);
    io.s_meas    = 12'(meas);
    io.cfg_we    = we;
    io.cfg_ch    = 2'(ch);
    io.cfg_addr  = 3'(addr);
    io.cfg_wdata = 20'(data);
    io.cfg_clr   = clr;
  endtask
  task automatic send(input int ch, input int meas, input int pid, input bit sat);
    drive(1'b1, ch, meas, 1'b0, 0, 0, 1'b0);
    sb_q.push_back('{ch, pid, sat, cyc});
  endtask
  task automatic cfg(input int ch, input int addr, input int data);
    drive(1'b0, ch, 0, 1'b1, addr, data, 1'b0);
  endtask
  task automatic clr(input int ch);
    drive(1'b0, ch, 0, 1'b0, 0, 0, 1'b1);
  endtask
  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
  endtask
  task automatic drain();
    int n = 0;
    idle();
    while (sb_q.size() != 0 && n < 20) begin
      idle();
      n++;
    end
    chk("drain_timeout", sb_q.size(), 0);
    sb_q.delete();
  endtask
  task automatic wait_ready(input string name);
    int n = 0;
    chk({name, "_s_ready_low"}, longint'(io.s_ready), 0);
    while (!io.s_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_init_cycles"}, n, 4);
  endtask
  // saturation run on ch2 with KP=KI=2047; expectations from a small reference model
  task automatic sat_run(input int sp, input int meas, input int lim_w);
    int e, integ, lim;
    longint v, r;
    cfg(2, CFG_KI, 2047);
    cfg(2, CFG_SETPOINT, sp);
    cfg(2, CFG_INT_LIM, lim_w);
    clr(2);
    lim = lim_w > 524287 ? 524287 : lim_w;
    e = sp - meas;
    e = e > 2047 ? 2047 : e < -2048 ? -2048 : e;
    integ = 0;
    for (int k = 0; k < 20; k++) begin
      integ += e;
      integ = integ > lim ? lim : integ < -lim ? -lim : integ;
      v = longint'(2047) * e + longint'(2047) * integ;
      r = (v + 512) >>> 10;
      if (r > 32767) send(2, meas, 32767, 1'b1);
      else if (r < -32768) send(2, meas, -32768, 1'b1);
      else send(2, meas, int'(r), 1'b0);
    end
    drain();
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog_timeout actual=%0d required=0", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0] = '{0, 1024, 100, 40, 60, 1'b0};
    vecs[1] = '{0, 512, 3, 0, 2, 1'b0};
    vecs[2] = '{0, 512, -3, 0, -1, 1'b0};
    vecs[3] = '{3, 1024, 0, -500, 500, 1'b0};
    vecs[4] = '{2, 2047, 2047, -2048, 4092, 1'b0};
    vecs[5] = '{2, 2047, -2048, 2047, -4094, 1'b0};
    vecs[6] = '{1, -1024, 0, 7, 7, 1'b0};
    vecs[7] = '{0, 1, 512, 0, 1, 1'b0};
    vecs[8] = '{0, 1, -512, 0, 0, 1'b0};
    vecs[9] = '{0, 1, -513, 0, -1, 1'b0};
    io.s_valid = 1'b0; io.s_ch = '0; io.s_meas = '0;
    io.cfg_we = 1'b0; io.cfg_ch = '0; io.cfg_addr = '0; io.cfg_wdata = '0; io.cfg_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", longint'(io.s_ready), 0);
    chk("rst_m_valid", longint'(io.m_valid), 0);
    chk("rst_m_ch", longint'(io.m_ch), 0);
    chk("rst_m_pid", longint'(io.m_pid), 0);
    chk("rst_m_sat", longint'(io.m_sat), 0);
    rst_n = 1'b1;
    wait_ready("boot");
    repeat (3) @(negedge clk);
    chk("ready_stays_high", longint'(io.s_ready), 1);
    for (int k = 0; k < 10; k++) begin
      cfg(vecs[k].ch, CFG_KP, vecs[k].kp);
      cfg(vecs[k].ch, CFG_SETPOINT, vecs[k].sp);
      send(vecs[k].ch, vecs[k].meas, vecs[k].pid, vecs[k].sat);
      drain();
    end
    cfg(0, CFG_KP, 0);
    cfg(0, CFG_KI, 1024);
    cfg(0, CFG_INT_LIM, 150);
    cfg(0, CFG_SETPOINT, 60);
    send(0, 0, 60, 1'b0);
    send(0, 0, 120, 1'b0);
    send(0, 0, 150, 1'b0);
    send(0, 0, 150, 1'b0);
    drain();
    clr(0);
    send(0, 0, 60, 1'b0);
    drain();
    cfg(1, CFG_KP, 0);
    cfg(1, CFG_KD, 1024);
    cfg(1, CFG_SETPOINT, 0);
    clr(1);
    send(1, -10, 10, 1'b0);
    send(1, -30, 20, 1'b0);
    clr(1);
    drain();
    send(1, -50, 50, 1'b0);
    drain();
    cfg(0, CFG_INT_LIM, 1000);
    cfg(0, CFG_SETPOINT, 0);
    cfg(1, CFG_KD, 0);
    cfg(1, CFG_KI, 1024);
    cfg(1, CFG_INT_LIM, 1000);
    clr(0);
    clr(1);
    send(0, -5, 5, 1'b0);
    send(1, 7, -7, 1'b0);
    send(0, -5, 10, 1'b0);
    send(1, 7, -14, 1'b0);
    drain();
    sat_run(2047, -2048, 524287);
    sat_run(-2048, 2047, 1048575);
    drive(1'b1, 0, 40, 1'b0, 0, 0, 1'b0);
    drive(1'b1, 0, 40, 1'b0, 0, 0, 1'b0);
    @(negedge clk);
    io.s_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ready("rerun");
    send(0, 40, 0, 1'b0);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
